// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Core-request / memory handshake bundle for dmem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int NUM_REQ_P = 4
);
    logic [NUM_REQ_P-1:0]       req_valid_i;
    logic [NUM_REQ_P-1:0]       req_wen_i;
    logic [NUM_REQ_P-1:0]       req_byte_i;
    logic [NUM_REQ_P-1:0][31:0] req_addr_i;
    logic [NUM_REQ_P-1:0][31:0] req_wdata_i;
    logic [NUM_REQ_P-1:0]       req_yumi_o;
    logic [NUM_REQ_P-1:0]       rsp_valid_o;
    logic [31:0]                rsp_data_o;
    logic [NUM_REQ_P-1:0]       rsp_yumi_i;

    logic                       mem_valid_o;
    logic                       mem_wen_o;
    logic                       mem_byte_o;
    logic [31:0]                mem_addr_o;
    logic [31:0]                mem_wdata_o;
    logic                       mem_yumi_i;
    logic                       mem_rsp_valid_i;
    logic [31:0]                mem_rsp_data_i;
    logic                       mem_rsp_yumi_o;

    modport master (
        input  req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, rsp_yumi_i,
        input  mem_yumi_i, mem_rsp_valid_i, mem_rsp_data_i,
        output req_yumi_o, rsp_valid_o, rsp_data_o,
        output mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_rsp_yumi_o
    );

    modport slave (
        output req_valid_i, req_wen_i, req_byte_i, req_addr_i, req_wdata_i, rsp_yumi_i,
        output mem_yumi_i, mem_rsp_valid_i, mem_rsp_data_i,
        input  req_yumi_o, rsp_valid_o, rsp_data_o,
        input  mem_valid_o, mem_wen_o, mem_byte_o, mem_addr_o, mem_wdata_o, mem_rsp_yumi_o
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin N-core data-memory arbiter, one transaction in flight.
//            Optional watchdog enabled by macro DMEM_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int NUM_REQ_P = 4,
    parameter int TIMEOUT_P = 255
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dmem_arbiter_if.master      bus,
    output logic                timeout_o
);
    localparam int IDX_W = $clog2(NUM_REQ_P);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic               r_wen;
    logic               r_byte;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;

    logic [IDX_W-1:0]   w_grant;
    logic [NUM_REQ_P-1:0] w_owner_oh;
    logic               w_issue;
    logic               w_wait;
    logic               w_done;
    logic               w_abort;

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin : p_grant
        logic [IDX_W-1:0] v_cand;
        v_cand  = '0;
        w_grant = '0;
        for (int i = NUM_REQ_P - 1; i >= 0; i--) begin
            v_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_REQ_P);
            if (bus.req_valid_i[v_cand]) begin
                w_grant = v_cand;
            end
        end
    end

    assign w_owner_oh = NUM_REQ_P'(1) << r_owner;
    assign w_issue    = (r_state == ST_ISSUE);
    assign w_wait     = (r_state == ST_WAIT_RSP);
    assign w_done     = w_wait && bus.mem_rsp_valid_i && bus.rsp_yumi_i[r_owner];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_wen    <= 1'b0;
            r_byte   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req_valid_i) begin
                        r_owner <= w_grant;
                        r_wen   <= bus.req_wen_i[w_grant];
                        r_byte  <= bus.req_byte_i[w_grant];
                        r_addr  <= bus.req_addr_i[w_grant];
                        r_wdata <= bus.req_wdata_i[w_grant];
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mem_yumi_i) begin
                        r_state <= ST_WAIT_RSP;
                    end else if (w_abort) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WAIT_RSP: begin
                    if (w_done) begin
                        r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ_P - 1)) ? '0 : r_owner + IDX_W'(1);
                        r_state  <= ST_IDLE;
                    end else if (w_abort) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_P + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout;
    logic            w_progress;

    // Forward progress this cycle (accept or completion) cancels the abort.
    assign w_progress = (w_issue && bus.mem_yumi_i) || w_done;
    assign w_abort    = (w_issue || w_wait) && !w_progress && (r_wdog == WD_W'(TIMEOUT_P - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_abort) begin
                r_timeout <= 1'b1;
            end
            if ((w_issue || w_wait) && !w_done && !w_abort) begin
                r_wdog <= r_wdog + WD_W'(1);
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_abort   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Gating with reset keeps every handshake quiet while reset is held.
    assign bus.req_yumi_o     = (reset && w_issue && bus.mem_yumi_i)      ? w_owner_oh : '0;
    assign bus.rsp_valid_o    = (reset && w_wait && bus.mem_rsp_valid_i)  ? w_owner_oh : '0;
    assign bus.rsp_data_o     = (reset && w_wait) ? bus.mem_rsp_data_i : 32'd0;
    assign bus.mem_rsp_yumi_o = reset && w_wait && bus.rsp_yumi_i[r_owner];

    assign bus.mem_valid_o    = reset && w_issue;
    assign bus.mem_wen_o      = reset && w_issue && r_wen;
    assign bus.mem_byte_o     = reset && w_issue && r_byte;
    assign bus.mem_addr_o     = (reset && w_issue) ? r_addr  : 32'd0;
    assign bus.mem_wdata_o    = (reset && w_issue) ? r_wdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed self-checking bench for dmem_arbiter (4 cores).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
    localparam int N = 4;
`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic clk;
    logic reset;
    logic timeout;
    int   n_checks;
    int   n_errors;

    dmem_arbiter_if #(.NUM_REQ_P(N)) bus ();

    dmem_arbiter #(.NUM_REQ_P(N), .TIMEOUT_P(TO)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid_i     = '0;
        bus.req_wen_i       = '0;
        bus.req_byte_i      = '0;
        bus.rsp_yumi_i      = '0;
        bus.mem_yumi_i      = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = 32'd0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mvalid"}, 32'(bus.mem_valid_o), 32'd0);
        check({tag, "_ryumi"},  32'(bus.req_yumi_o), 32'd0);
        check({tag, "_rvalid"}, 32'(bus.rsp_valid_o), 32'd0);
        check({tag, "_rdata"},  bus.rsp_data_o, 32'd0);
        check({tag, "_myumi"},  32'(bus.mem_rsp_yumi_o), 32'd0);
        check({tag, "_maddr"},  bus.mem_addr_o, 32'd0);
    endtask

    // Entered in an IDLE cycle with requests already presented; leaves in IDLE.
    task automatic run_txn(input int owner, input logic [31:0] addr, input logic wen,
                           input logic bsel, input logic [31:0] wdata, input logic [31:0] rdata);
        tick();
        bus.mem_yumi_i = 1'b1;
        #1;
        check("txn_mvalid", 32'(bus.mem_valid_o), 32'd1);
        check("txn_maddr",  bus.mem_addr_o, addr);
        check("txn_mwen",   32'(bus.mem_wen_o), 32'(wen));
        check("txn_mbyte",  32'(bus.mem_byte_o), 32'(bsel));
        check("txn_mwdata", bus.mem_wdata_o, wdata);
        check("txn_ryumi",  32'(bus.req_yumi_o), 32'(1) << owner);
        tick();
        bus.mem_yumi_i      = 1'b0;
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = rdata;
        bus.rsp_yumi_i      = '1;
        #1;
        check("txn_mvalid_off", 32'(bus.mem_valid_o), 32'd0);
        check("txn_rvalid", 32'(bus.rsp_valid_o), 32'(1) << owner);
        check("txn_rdata",  bus.rsp_data_o, rdata);
        check("txn_myumi",  32'(bus.mem_rsp_yumi_o), 32'd1);
        tick();
        bus.mem_rsp_valid_i = 1'b0;
        bus.rsp_yumi_i      = '0;
        #1;
        check("txn_rdata_idle", bus.rsp_data_o, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        idle_inputs();
        for (int i = 0; i < N; i++) begin
            bus.req_addr_i[i]  = 32'h100 + 32'(i) * 4;
            bus.req_wdata_i[i] = 32'h1000 + 32'(i);
        end
        tick();
        tick();
        check_quiet("rst");
        check("rst_timeout", 32'(timeout), 32'd0);

        // Requests during reset must not be granted.
        bus.req_valid_i = '1;
        tick();
        tick();
        check_quiet("rst_req");

        // Continuous requests from all cores after reset: 0,1,2,3,0.
        reset = 1'b1;
        run_txn(0, 32'h100, 1'b0, 1'b0, 32'h1000, 32'h11110000);
        run_txn(1, 32'h104, 1'b0, 1'b0, 32'h1001, 32'h11110001);
        run_txn(2, 32'h108, 1'b0, 1'b0, 32'h1002, 32'h11110002);
        run_txn(3, 32'h10C, 1'b0, 1'b0, 32'h1003, 32'h11110003);
        run_txn(0, 32'h100, 1'b0, 1'b0, 32'h1000, 32'h11110004);

        // Single core 1 load at 0x40 (rr_ptr now 1).
        bus.req_valid_i   = 4'b0010;
        bus.req_addr_i[1] = 32'h40;
        run_txn(1, 32'h40, 1'b0, 1'b0, 32'h1001, 32'hDEADBEEF);

        // rr_ptr=2 with cores 0 and 3 requesting: wrap search picks 3. Byte store.
        bus.req_valid_i    = 4'b1001;
        bus.req_wen_i      = 4'b1000;
        bus.req_byte_i     = 4'b1000;
        bus.req_wdata_i[3] = 32'hA5A5A5A5;
        run_txn(3, 32'h10C, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h0);
        bus.req_wen_i  = '0;
        bus.req_byte_i = '0;

        // rr_ptr=0 with cores 1 and 2 requesting: picks 1.
        bus.req_valid_i = 4'b0110;
        run_txn(1, 32'h40, 1'b0, 1'b0, 32'h1001, 32'h12345678);

        // Core 2: drops valid and changes addr after grant; stray rsp in ISSUE.
        bus.req_valid_i   = 4'b0100;
        bus.req_addr_i[2] = 32'h200;
        tick();
        bus.req_valid_i     = '0;
        bus.req_addr_i[2]   = 32'hFFFF;
        bus.mem_rsp_valid_i = 1'b1;
        bus.rsp_yumi_i      = 4'b0100;
        #1;
        check("drop_maddr", bus.mem_addr_o, 32'h200);
        check("issue_rsp_ignored_myumi", 32'(bus.mem_rsp_yumi_o), 32'd0);
        check("issue_rsp_ignored_rvalid", 32'(bus.rsp_valid_o), 32'd0);
        tick();
        bus.mem_rsp_valid_i = 1'b0;
        bus.rsp_yumi_i      = '0;
        bus.mem_yumi_i      = 1'b1;
        #1;
        check("drop_maddr2", bus.mem_addr_o, 32'h200);
        check("drop_ryumi", 32'(bus.req_yumi_o), 32'h4);
        tick();
        bus.mem_yumi_i      = 1'b0;
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = 32'hCAFEF00D;
        bus.rsp_yumi_i      = 4'b1011;
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < 2; c++) begin
                #1;
                check("hold_rvalid", 32'(bus.rsp_valid_o), 32'h4);
                check("hold_myumi", 32'(bus.mem_rsp_yumi_o), 32'd0);
                if (bus.mem_rsp_yumi_o) pulses++;
                tick();
            end
            bus.rsp_yumi_i = 4'b0100;
            #1;
            check("hold_rdata", bus.rsp_data_o, 32'hCAFEF00D);
            if (bus.mem_rsp_yumi_o) pulses++;
            tick();
            #1;
            if (bus.mem_rsp_yumi_o) pulses++;
            check("hold_pulses", 32'(pulses), 32'd1);
            check("idle_rsp_ignored_rvalid", 32'(bus.rsp_valid_o), 32'd0);
        end
        bus.mem_rsp_valid_i = 1'b0;
        bus.rsp_yumi_i      = '0;

        // Reset in WAIT_RSP (rr_ptr=3 beforehand).
        bus.req_valid_i = 4'b0001;
        tick();
        bus.req_valid_i = '0;
        bus.mem_yumi_i  = 1'b1;
        tick();
        bus.mem_yumi_i      = 1'b0;
        bus.mem_rsp_valid_i = 1'b1;
        #1;
        check("wait_rvalid", 32'(bus.rsp_valid_o), 32'h1);
        reset          = 1'b0;
        bus.rsp_yumi_i = 4'b0001;
        #1;
        check("rst_wait_myumi", 32'(bus.mem_rsp_yumi_o), 32'd0);
        check("rst_wait_rvalid", 32'(bus.rsp_valid_o), 32'd0);
        tick();
        check_quiet("rst_wait");
        idle_inputs();
        reset = 1'b1;
        bus.req_valid_i = '1;
        run_txn(0, 32'h100, 1'b0, 1'b0, 32'h1000, 32'h55AA55AA);

        // Memory never accepts.
        bus.req_valid_i = 4'b0001;
        tick();
        bus.req_valid_i = '0;
`ifdef DMEM_ARB_TIMEOUT_EN
        for (int c = 0; c < 7; c++) tick();
        check("to_before_mvalid", 32'(bus.mem_valid_o), 32'd1);
        check("to_before_flag", 32'(timeout), 32'd0);
        tick();
        check("to_after_mvalid", 32'(bus.mem_valid_o), 32'd0);
        check("to_after_flag", 32'(timeout), 32'd1);
        check("to_after_ryumi", 32'(bus.req_yumi_o), 32'd0);
`else
        for (int c = 0; c < 300; c++) tick();
        check("noto_mvalid", 32'(bus.mem_valid_o), 32'd1);
        check("noto_flag", 32'(timeout), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter NUM_REQ_P, default 4: number of core requesters, 2..8.
REQ-002 Parameter TIMEOUT_P, default 255: watchdog limit in cycles, used only when DMEM_ARB_TIMEOUT_EN is defined.
REQ-003 Port clk, input, 1: clock; all state changes on posedge.
REQ-004 Port reset, input, 1: synchronous, active-low; clock clk.
REQ-005 Port req_valid_i, input, NUM_REQ_P: per-core request valid.
REQ-006 Port req_wen_i / req_byte_i, input, NUM_REQ_P each: store / byte-not-word per core.
REQ-007 Port req_addr_i / req_wdata_i, input, NUM_REQ_P x 32 each: per-core address and write data.
REQ-008 Port req_yumi_o, input-ack, output, NUM_REQ_P: one-hot, request accepted by memory.
REQ-009 Port rsp_valid_o, output, NUM_REQ_P: one-hot, response available to the owning core.
REQ-010 Port rsp_data_o, output, 32: read data, shared by all cores.
REQ-011 Port rsp_yumi_i, input, NUM_REQ_P: core consumes its response.
REQ-012 Ports mem_valid_o, mem_wen_o, mem_byte_o (output, 1 each); mem_addr_o, mem_wdata_o (output, 32 each): memory request.
REQ-013 Ports mem_yumi_i, input, 1 and mem_rsp_valid_i, input, 1 and mem_rsp_data_i, input, 32 and mem_rsp_yumi_o, output, 1: memory handshake.
REQ-014 Port timeout_o, output, 1: watchdog error flag; constant 0 when the feature is compiled out.

Function
REQ-015 States: IDLE, ISSUE, WAIT_RSP; exactly one transaction outstanding.
REQ-016 IDLE: when any req_valid_i is set, grant the first set bit at or after rr_ptr (wrapping modulo NUM_REQ_P); latch owner, wen, byte, addr and wdata; next state ISSUE.
REQ-017 ISSUE: mem_valid_o=1 and memory fields driven from the latched copy, not the live inputs.
REQ-018 ISSUE: on mem_yumi_i, pulse req_yumi_o[owner] in the same cycle; next state WAIT_RSP.
REQ-019 WAIT_RSP: rsp_valid_o[owner] = mem_rsp_valid_i; rsp_data_o = mem_rsp_data_i; mem_rsp_yumi_o = rsp_yumi_i[owner].
REQ-020 WAIT_RSP: when mem_rsp_valid_i and rsp_yumi_i[owner] are both set, set rr_ptr = (owner+1) mod NUM_REQ_P and return to IDLE.
REQ-021 Stores also wait for the memory response; the core yumis it like a load.
REQ-022 Minimum transaction latency is 3 cycles (grant, issue, response); the next grant occurs in the cycle after return to IDLE.
REQ-023 rsp_yumi_i bits of non-owners are ignored; rsp_valid_o is never set for a non-owner.
REQ-024 If the owner drops req_valid_i after grant, the latched transaction still completes.
REQ-025 mem_rsp_valid_i in IDLE or ISSUE is ignored and is not yumied.
REQ-026 rsp_data_o = 0 outside WAIT_RSP.

Reset
REQ-027 When reset=0 at posedge, set: state=IDLE, rr_ptr=0, owner=0, latched fields=0, watchdog=0, timeout_o=0.
REQ-028 During and after reset, all outputs = 0 until the first grant.
REQ-029 Reset mid-transaction abandons the transaction without issuing a yumi to any side.

Configuration
REQ-030 Macro DMEM_ARB_TIMEOUT_EN defined: a counter increments each cycle in ISSUE/WAIT_RSP and clears on return to IDLE.
REQ-031 When the counter reaches TIMEOUT_P, set timeout_o sticky until reset and force state to IDLE without yumis.
REQ-032 Macro undefined: no counter is built, timeout_o=0, and the arbiter waits indefinitely.

Verification
REQ-033 Single core 1 load at addr 0x40, mem_yumi next cycle, rsp 0xDEADBEEF -> req_yumi_o=0010, rsp_valid_o=0010, rsp_data_o=0xDEADBEEF, total 3 cycles.
REQ-034 All 4 cores request continuously from reset -> grant order 0,1,2,3,0; no core granted twice before the others.
REQ-035 Core 2 granted, drops valid in ISSUE, addr input changes to 0xFFFF -> mem_addr_o keeps the latched value and the transaction completes.
REQ-036 mem_rsp_valid_i=1 held for 2 cycles before owner rsp_yumi_i -> state stays WAIT_RSP; mem_rsp_yumi_o pulses exactly once.
REQ-037 Reset=0 asserted in WAIT_RSP -> next cycle all outputs 0, rr_ptr=0.
REQ-038 With DMEM_ARB_TIMEOUT_EN and TIMEOUT_P=8, memory never yumis -> timeout_o=1 after 8 cycles and state returns to IDLE; without the macro, mem_valid_o stays 1.
